// File: rtl/c3lib_ckmux_pkg.sv
// Shared types and helpers for the c3lib clock-mux selection sequencer.
// Holds the sequencer state enum, the upper bound on clock sources and a
// one-hot encoder that maps out-of-range indices to all-zero.
package c3lib_ckmux_pkg;

  localparam int CKMUX_MAX_NUM_CK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OFF  = 2'd1,
    ON   = 2'd2,
    TST  = 2'd3
  } ckmux_state_e;

  // One-hot encode idx over num sources; an index at or above num gives zero
  // so a bad select can never enable a gate.
  function automatic logic [CKMUX_MAX_NUM_CK-1:0] ckmux_onehot(input logic [4:0] idx,
                                                              input int num);
    logic [CKMUX_MAX_NUM_CK-1:0] v;
    v = '0;
    if (32'(idx) < 32'(num)) begin
      v = CKMUX_MAX_NUM_CK'(1) << idx;
    end
    return v;
  endfunction

endpackage

// File: rtl/c3lib_ckmux_dwell_cnt.sv
// Loadable down-counter used to time the gate-off dwell and the settle window.
// Loads on state entry, counts down to 1 and parks there; done marks the
// final cycle of the window.
module c3lib_ckmux_dwell_cnt #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Reload on request, otherwise step down and stop at 1 rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= W'(1);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt > W'(1)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/c3lib_ckmux_sel_seq.sv
// Break-before-make selection sequencer for an N-input glitch-free clock mux.
// Each switch turns every gate off for OFF_CYC cycles, enables only the new
// gate, waits ON_CYC settle cycles and then acks. The test override is only
// built when C3LIB_CKMUX_SEL_TST_EN is defined.
module c3lib_ckmux_sel_seq
  import c3lib_ckmux_pkg::*;
#(
  parameter int NUM_CK  = 4,
  parameter int SEL_W   = $clog2(NUM_CK),
  parameter int OFF_CYC = 4,
  parameter int ON_CYC  = 2,
  parameter int RST_SEL = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [SEL_W-1:0]  i_sel_req,
  input  logic              i_sel_vld,
  output logic              o_sel_rdy,
  output logic              o_sel_ack,
  output logic              o_sel_err,
  output logic [SEL_W-1:0]  o_cur_sel,
  output logic [NUM_CK-1:0] o_ck_en,
  output logic              o_busy,
  input  logic              i_tst_override,
  input  logic [SEL_W-1:0]  i_tst_sel
);

  localparam int DW = $clog2(((OFF_CYC > ON_CYC) ? OFF_CYC : ON_CYC) + 1);
  localparam logic [SEL_W-1:0]  RST_SEL_V = SEL_W'(RST_SEL);
  localparam logic [NUM_CK-1:0] RST_CK_EN = NUM_CK'(1) << RST_SEL;

  ckmux_state_e      r_state;
  logic [SEL_W-1:0]  r_cur_sel;
  logic [SEL_W-1:0]  r_tgt_sel;
  logic [NUM_CK-1:0] r_ck_en;
  logic              r_ack;
  logic              r_err;
  logic              r_busy;
  logic              r_rdy;
  logic              r_silent;

  logic              w_tst;
  logic              w_tst_release;
  logic              w_accept;
  logic              w_req_oob;
  logic              w_req_same;
  logic              w_go_off;
  logic              w_go_on;
  logic              w_done;
  logic              w_load;
  logic [DW-1:0]     w_load_val;
  logic [NUM_CK-1:0] w_tgt_oh;

`ifdef C3LIB_CKMUX_SEL_TST_EN
  logic [NUM_CK-1:0] w_tst_oh;
  assign w_tst         = i_tst_override;
  assign w_tst_release = (r_state == TST) && !i_tst_override;
  assign w_tst_oh      = NUM_CK'(ckmux_onehot(5'(i_tst_sel), NUM_CK));
`else
  logic w_unused_tst;
  assign w_tst         = 1'b0;
  assign w_tst_release = 1'b0;
  assign w_unused_tst  = ^{i_tst_override, i_tst_sel};
`endif

  assign w_accept   = i_sel_vld && r_rdy && (r_state == IDLE) && !w_tst;
  assign w_req_oob  = ({1'b0, i_sel_req} >= (SEL_W + 1)'(NUM_CK));
  assign w_req_same = (i_sel_req == r_cur_sel);
  assign w_go_off   = (w_accept && !w_req_oob && !w_req_same) || w_tst_release;
  assign w_go_on    = (r_state == OFF) && w_done && !w_tst;
  assign w_load     = w_go_off || w_go_on;
  assign w_load_val = w_go_off ? DW'(OFF_CYC) : DW'(ON_CYC);
  assign w_tgt_oh   = NUM_CK'(ckmux_onehot(5'(r_tgt_sel), NUM_CK));

  c3lib_ckmux_dwell_cnt #(
    .W (DW)
  ) u_dwell_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Sequencer FSM; every output is a register updated on the state transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cur_sel <= RST_SEL_V;
      r_tgt_sel <= RST_SEL_V;
      r_ck_en   <= RST_CK_EN;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_rdy     <= 1'b1;
      r_silent  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
`ifdef C3LIB_CKMUX_SEL_TST_EN
      if (w_tst) begin
        r_state <= TST;
        r_ck_en <= w_tst_oh;
        r_busy  <= 1'b1;
        r_rdy   <= 1'b0;
      end else begin
`else
      begin
`endif
        case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
            r_rdy  <= 1'b1;
            if (w_accept) begin
              if (w_req_oob) begin
                r_ack <= 1'b1;
                r_err <= 1'b1;
                r_rdy <= 1'b0;
              end else if (w_req_same) begin
                r_ack <= 1'b1;
                r_rdy <= 1'b0;
              end else begin
                r_state   <= OFF;
                r_tgt_sel <= i_sel_req;
                r_ck_en   <= '0;
                r_busy    <= 1'b1;
                r_rdy     <= 1'b0;
                r_silent  <= 1'b0;
              end
            end
          end
          OFF: begin
            if (w_done) begin
              r_state   <= ON;
              r_ck_en   <= w_tgt_oh;
              r_cur_sel <= r_tgt_sel;
            end
          end
          ON: begin
            if (w_done) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_rdy   <= 1'b1;
              r_ack   <= !r_silent;
            end
          end
`ifdef C3LIB_CKMUX_SEL_TST_EN
          TST: begin
            r_state   <= OFF;
            r_tgt_sel <= r_cur_sel;
            r_ck_en   <= '0;
            r_busy    <= 1'b1;
            r_rdy     <= 1'b0;
            r_silent  <= 1'b1;
          end
`endif
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_sel_rdy = r_rdy;
  assign o_sel_ack = r_ack;
  assign o_sel_err = r_err;
  assign o_cur_sel = r_cur_sel;
  assign o_ck_en   = r_ck_en;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_c3lib_ckmux_sel_seq.sv
// Directed bench for c3lib_ckmux_sel_seq: a 4-source instance for the main
// sequences and a 3-source instance for the out-of-range request case.
// Checks the override path when C3LIB_CKMUX_SEL_TST_EN is defined, and that
// the override is ignored otherwise.
module tb_c3lib_ckmux_sel_seq;

  logic       clk;
  logic       rstN;
  logic [1:0] selReq;
  logic       selVld;
  logic       tstOverride;
  logic [1:0] tstSel;
  logic       selRdy, selAck, selErr, busy;
  logic [1:0] curSel;
  logic [3:0] ckEn;

  logic [1:0] selReq3;
  logic       selVld3;
  logic       tstOverride3;
  logic [1:0] tstSel3;
  logic       selRdy3, selAck3, selErr3, busy3;
  logic [1:0] curSel3;
  logic [2:0] ckEn3;

  logic [9:0] obsMain, expMain;
  logic [8:0] obs3, exp3;
  int vectors;
  int miscompares;

  assign obsMain = {ckEn, curSel, selAck, selErr, busy, selRdy};
  assign obs3    = {ckEn3, curSel3, selAck3, selErr3, busy3, selRdy3};

  c3lib_ckmux_sel_seq #(
    .NUM_CK (4), .OFF_CYC (4), .ON_CYC (2), .RST_SEL (0)
  ) dut (
    .i_clk (clk), .i_rst_n (rstN), .i_sel_req (selReq), .i_sel_vld (selVld),
    .o_sel_rdy (selRdy), .o_sel_ack (selAck), .o_sel_err (selErr),
    .o_cur_sel (curSel), .o_ck_en (ckEn), .o_busy (busy),
    .i_tst_override (tstOverride), .i_tst_sel (tstSel)
  );

  c3lib_ckmux_sel_seq #(
    .NUM_CK (3), .OFF_CYC (4), .ON_CYC (2), .RST_SEL (0)
  ) dut3 (
    .i_clk (clk), .i_rst_n (rstN), .i_sel_req (selReq3), .i_sel_vld (selVld3),
    .o_sel_rdy (selRdy3), .o_sel_ack (selAck3), .o_sel_err (selErr3),
    .o_cur_sel (curSel3), .o_ck_en (ckEn3), .o_busy (busy3),
    .i_tst_override (tstOverride3), .i_tst_sel (tstSel3)
  );

  // Free-running control clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and settle just after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reset values on both instances, during and just after reset.
  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) stepCycle();
    expMain = {4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obsMain !== expMain) begin
      $display("[TB] FAIL reset_main: got %b expected %b", obsMain, expMain);
      miscompares++;
    end
    exp3 = {3'b001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs3 !== exp3) begin
      $display("[TB] FAIL reset_n3: got %b expected %b", obs3, exp3);
      miscompares++;
    end
    #2 rstN = 1'b1;
    stepCycle();
    vectors++;
    if (obsMain !== expMain) begin
      $display("[TB] FAIL reset_release: got %b expected %b", obsMain, expMain);
      miscompares++;
    end
  endtask

  // Request the source already selected: ack next cycle, gates untouched.
  task automatic test_trivial();
    selReq = 2'd0;
    selVld = 1'b1;
    stepCycle();
    selVld = 1'b0;
    expMain = {4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obsMain !== expMain) begin
      $display("[TB] FAIL trivial_ack: got %b expected %b", obsMain, expMain);
      miscompares++;
    end
    stepCycle();
    expMain = {4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obsMain !== expMain) begin
      $display("[TB] FAIL trivial_after: got %b expected %b", obsMain, expMain);
      miscompares++;
    end
  endtask

  // Full 0 -> 2 switch: four dark cycles, new gate at T+5, ack at T+7.
  task automatic test_switch();
    selReq = 2'd2;
    selVld = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      if (k == 1) selVld = 1'b0;
      expMain = {(k <= 4) ? 4'b0000 : 4'b0100, (k <= 4) ? 2'd0 : 2'd2,
                 (k == 7), 1'b0, (k <= 6), (k >= 7)};
      vectors++;
      if (obsMain !== expMain) begin
        $display("[TB] FAIL switch k=%0d: got %b expected %b", k, obsMain, expMain);
        miscompares++;
      end
    end
  endtask

  // Out-of-range request on the 3-source instance: ack plus err, no change.
  task automatic test_error();
    selReq3 = 2'd3;
    selVld3 = 1'b1;
    stepCycle();
    selVld3 = 1'b0;
    exp3 = {3'b001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs3 !== exp3) begin
      $display("[TB] FAIL error_ack: got %b expected %b", obs3, exp3);
      miscompares++;
    end
    stepCycle();
    exp3 = {3'b001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs3 !== exp3) begin
      $display("[TB] FAIL error_after: got %b expected %b", obs3, exp3);
      miscompares++;
    end
  endtask

  // Valid held through a switch with a changing request: the first request
  // runs to completion, the one seen in the ack cycle starts right after.
  task automatic test_back_to_back();
    selReq = 2'd1;
    selVld = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      stepCycle();
      if (k == 1) selReq = 2'd3;
      expMain = {(k <= 4) ? 4'b0000 : (k <= 7) ? 4'b0010 : (k <= 11) ? 4'b0000 : 4'b1000,
                 (k <= 4) ? 2'd2 : (k <= 11) ? 2'd1 : 2'd3,
                 (k == 7 || k == 14), 1'b0,
                 (k <= 6 || (k >= 8 && k <= 13)), (k == 7 || k >= 14)};
      vectors++;
      if (obsMain !== expMain) begin
        $display("[TB] FAIL back_to_back k=%0d: got %b expected %b", k, obsMain, expMain);
        miscompares++;
      end
      if (k == 8) selVld = 1'b0;
    end
  endtask

  // Reset two cycles into a 0 -> 2 switch restores reset values at once and
  // no ack ever follows.
  task automatic test_reset_mid();
    #2 rstN = 1'b0;
    stepCycle();
    rstN = 1'b1;
    stepCycle();
    selReq = 2'd2;
    selVld = 1'b1;
    stepCycle();
    selVld = 1'b0;
    stepCycle();
    expMain = {4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vectors++;
    if (obsMain !== expMain) begin
      $display("[TB] FAIL reset_mid_pre: got %b expected %b", obsMain, expMain);
      miscompares++;
    end
    #2 rstN = 1'b0;
    #1;
    expMain = {4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obsMain !== expMain) begin
      $display("[TB] FAIL reset_mid_async: got %b expected %b", obsMain, expMain);
      miscompares++;
    end
    stepCycle();
    stepCycle();
    rstN = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      stepCycle();
      vectors++;
      if (obsMain !== expMain) begin
        $display("[TB] FAIL reset_mid_after k=%0d: got %b expected %b", k, obsMain, expMain);
        miscompares++;
      end
    end
  endtask

`ifdef C3LIB_CKMUX_SEL_TST_EN
  // Override during OFF aborts the switch; release runs a silent sequence
  // back to the unchanged current selection.
  task automatic test_tst();
    selReq = 2'd2;
    selVld = 1'b1;
    stepCycle();
    selVld = 1'b0;
    stepCycle();
    tstOverride = 1'b1;
    tstSel = 2'd3;
    stepCycle();
    vectors++;
    if ({ckEn, curSel, selAck, selRdy} !== {4'b1000, 2'd0, 1'b0, 1'b0}) begin
      $display("[TB] FAIL tst_enter: got %b expected %b",
               {ckEn, curSel, selAck, selRdy}, {4'b1000, 2'd0, 1'b0, 1'b0});
      miscompares++;
    end
    tstSel = 2'd2;
    stepCycle();
    vectors++;
    if ({ckEn, selAck} !== {4'b0100, 1'b0}) begin
      $display("[TB] FAIL tst_follow: got %b expected %b", {ckEn, selAck}, {4'b0100, 1'b0});
      miscompares++;
    end
    tstOverride = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      stepCycle();
      expMain = {(k <= 4) ? 4'b0000 : 4'b0001, 2'd0, 1'b0, 1'b0, (k <= 6), (k >= 7)};
      vectors++;
      if (obsMain !== expMain) begin
        $display("[TB] FAIL tst_release k=%0d: got %b expected %b", k, obsMain, expMain);
        miscompares++;
      end
    end
    tstOverride3 = 1'b1;
    tstSel3 = 2'd3;
    stepCycle();
    vectors++;
    if ({ckEn3, selAck3} !== {3'b000, 1'b0}) begin
      $display("[TB] FAIL tst_oob_sel: got %b expected %b", {ckEn3, selAck3}, {3'b000, 1'b0});
      miscompares++;
    end
    tstSel3 = 2'd1;
    stepCycle();
    vectors++;
    if ({ckEn3, selAck3} !== {3'b010, 1'b0}) begin
      $display("[TB] FAIL tst_n3_sel: got %b expected %b", {ckEn3, selAck3}, {3'b010, 1'b0});
      miscompares++;
    end
    tstOverride3 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      stepCycle();
      vectors++;
      if ({ckEn3, selAck3} !== {(k <= 4) ? 3'b000 : 3'b001, 1'b0}) begin
        $display("[TB] FAIL tst_n3_release k=%0d: got %b expected %b", k,
                 {ckEn3, selAck3}, {(k <= 4) ? 3'b000 : 3'b001, 1'b0});
        miscompares++;
      end
    end
  endtask
`else
  // Without the override built in, the same stimulus leaves the switch intact.
  task automatic test_tst();
    selReq = 2'd2;
    selVld = 1'b1;
    stepCycle();
    selVld = 1'b0;
    stepCycle();
    tstOverride = 1'b1;
    tstSel = 2'd3;
    tstOverride3 = 1'b1;
    tstSel3 = 2'd1;
    for (int k = 3; k <= 8; k++) begin
      stepCycle();
      expMain = {(k <= 4) ? 4'b0000 : 4'b0100, (k <= 4) ? 2'd0 : 2'd2,
                 (k == 7), 1'b0, (k <= 6), (k >= 7)};
      vectors++;
      if (obsMain !== expMain) begin
        $display("[TB] FAIL tst_ignored k=%0d: got %b expected %b", k, obsMain, expMain);
        miscompares++;
      end
    end
    vectors++;
    if ({ckEn3, selAck3} !== {3'b001, 1'b0}) begin
      $display("[TB] FAIL tst_ignored_n3: got %b expected %b", {ckEn3, selAck3}, {3'b001, 1'b0});
      miscompares++;
    end
    tstOverride = 1'b0;
    tstOverride3 = 1'b0;
    stepCycle();
    expMain = {4'b0100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obsMain !== expMain) begin
      $display("[TB] FAIL tst_ignored_after: got %b expected %b", obsMain, expMain);
      miscompares++;
    end
  endtask
`endif

  // Run every scenario in order and report the totals.
  initial begin
    vectors = 0;
    miscompares = 0;
    rstN = 1'b0;
    selReq = '0;
    selVld = 1'b0;
    tstOverride = 1'b0;
    tstSel = '0;
    selReq3 = '0;
    selVld3 = 1'b0;
    tstOverride3 = 1'b0;
    tstSel3 = '0;
    $display("[TB] starting c3lib_ckmux_sel_seq directed tests");
    test_reset();
    test_trivial();
    test_switch();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_tst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
